// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the register-file write port between ALU and load writeback, with forwarding
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   alu_valid_i/alu_ready_o        ALU writeback handshake, alu_regnum_i/alu_data_i payload
//   mem_valid_i/mem_ready_o        load writeback handshake, mem_regnum_i/mem_data_i payload
//   regnum2_o/din0_o/we0_o         registered register-file write port
//   rd_regnum0_i/rd_regnum1_i      register-file read addresses
//   byp_hit0_o/byp_data0_o         forwarded value for read port 0
//   byp_hit1_o/byp_data1_o         forwarded value for read port 1
//   err_range_o                    one-cycle pulse when an out-of-range write is dropped
module gpr_wb_arbiter #(
    parameter int NREG    = 16,
    parameter int MAXWAIT = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_regnum_i,
    input  logic [31:0] alu_data_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [4:0]  mem_regnum_i,
    input  logic [31:0] mem_data_i,
    output logic [4:0]  regnum2_o,
    output logic [31:0] din0_o,
    output logic        we0_o,
    input  logic [4:0]  rd_regnum0_i,
    input  logic [4:0]  rd_regnum1_i,
    output logic        byp_hit0_o,
    output logic [31:0] byp_data0_o,
    output logic        byp_hit1_o,
    output logic [31:0] byp_data1_o,
    output logic        err_range_o
);
    localparam logic [5:0] NREG_L    = 6'(NREG);
    localparam logic [3:0] MAXWAIT_L = 4'(MAXWAIT);

    logic        alu_full_q, alu_full_d, mem_full_q, mem_full_d;
    logic [4:0]  alu_reg_q, alu_reg_d, mem_reg_q, mem_reg_d;
    logic [31:0] alu_dat_q, alu_dat_d, mem_dat_q, mem_dat_d;
    logic        alu_young_q, alu_young_d;
    logic [3:0]  wait_q, wait_d;
    logic        we0_q, we0_d, err_q, err_d;
    logic [4:0]  regnum2_q, regnum2_d;
    logic [31:0] din0_q, din0_d;
    logic        both_full, gnt_alu, gnt_mem;
    logic        alu_acc, mem_acc, alu_oor, mem_oor, alu_keep, mem_keep;
    logic [1:0][4:0]  rd;
    logic [1:0]       hit_a, hit_m, hit_w, hit;
    logic [1:0][31:0] dat;

    // Equal destinations must commit in arrival order, so the older entry wins there;
    // otherwise the starvation guard, then MEM first.
    always_comb begin
        both_full = alu_full_q && mem_full_q;
        gnt_alu   = (both_full && alu_reg_q == mem_reg_q) ? !alu_young_q :
                    (both_full && wait_q >= MAXWAIT_L) ? 1'b1 : alu_full_q && !mem_full_q;
        gnt_mem   = mem_full_q && !gnt_alu;
    end

    // A granted buffer drains this edge, so it may refill at the same time.
    assign alu_ready_o = rst_n_i && (!alu_full_q || gnt_alu);
    assign mem_ready_o = rst_n_i && (!mem_full_q || gnt_mem);

    always_comb begin
        alu_acc  = alu_valid_i && alu_ready_o;
        mem_acc  = mem_valid_i && mem_ready_o;
        alu_oor  = alu_acc && {1'b0, alu_regnum_i} >= NREG_L;
        mem_oor  = mem_acc && {1'b0, mem_regnum_i} >= NREG_L;
        alu_keep = alu_acc && alu_regnum_i != 5'd0 && !alu_oor;
        mem_keep = mem_acc && mem_regnum_i != 5'd0 && !mem_oor;
    end

    always_comb begin
        alu_full_d  = alu_keep || (alu_full_q && !gnt_alu);
        mem_full_d  = mem_keep || (mem_full_q && !gnt_mem);
        alu_reg_d   = alu_keep ? alu_regnum_i : alu_reg_q;
        alu_dat_d   = alu_keep ? alu_data_i : alu_dat_q;
        mem_reg_d   = mem_keep ? mem_regnum_i : mem_reg_q;
        mem_dat_d   = mem_keep ? mem_data_i : mem_dat_q;
        // Simultaneous loads count ALU as younger.
        alu_young_d = (alu_keep && (mem_keep || (mem_full_q && !gnt_mem))) ? 1'b1 :
                      (mem_keep && alu_full_q && !gnt_alu) ? 1'b0 : alu_young_q;
        wait_d      = (!alu_full_q || gnt_alu) ? 4'd0 :
                      (wait_q == 4'hf) ? wait_q : wait_q + 4'd1;
        we0_d       = gnt_alu || gnt_mem;
        regnum2_d   = gnt_alu ? alu_reg_q : gnt_mem ? mem_reg_q : regnum2_q;
        din0_d      = gnt_alu ? alu_dat_q : gnt_mem ? mem_dat_q : din0_q;
        err_d       = alu_oor || mem_oor;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            alu_full_q  <= 1'b0;
            mem_full_q  <= 1'b0;
            alu_reg_q   <= 5'd0;
            alu_dat_q   <= 32'd0;
            mem_reg_q   <= 5'd0;
            mem_dat_q   <= 32'd0;
            alu_young_q <= 1'b0;
            wait_q      <= 4'd0;
            we0_q       <= 1'b0;
            regnum2_q   <= 5'd0;
            din0_q      <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            alu_full_q  <= alu_full_d;
            mem_full_q  <= mem_full_d;
            alu_reg_q   <= alu_reg_d;
            alu_dat_q   <= alu_dat_d;
            mem_reg_q   <= mem_reg_d;
            mem_dat_q   <= mem_dat_d;
            alu_young_q <= alu_young_d;
            wait_q      <= wait_d;
            we0_q       <= we0_d;
            regnum2_q   <= regnum2_d;
            din0_q      <= din0_d;
            err_q       <= err_d;
        end
    end

    assign rd = {rd_regnum1_i, rd_regnum0_i};

    // Newest pending value first: younger buffer, older buffer, then the write in flight.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            hit_a[k] = alu_full_q && alu_reg_q == rd[k];
            hit_m[k] = mem_full_q && mem_reg_q == rd[k];
            hit_w[k] = we0_q && regnum2_q == rd[k];
            hit[k]   = rd[k] != 5'd0 && (hit_a[k] || hit_m[k] || hit_w[k]);
            dat[k]   = (rd[k] == 5'd0) ? 32'd0 :
                       (hit_a[k] && hit_m[k]) ? (alu_young_q ? alu_dat_q : mem_dat_q) :
                       hit_a[k] ? alu_dat_q : hit_m[k] ? mem_dat_q : hit_w[k] ? din0_q : 32'd0;
        end
    end

    assign byp_hit0_o  = hit[0];
    assign byp_hit1_o  = hit[1];
    assign byp_data0_o = dat[0];
    assign byp_data1_o = dat[1];
    assign we0_o       = we0_q;
    assign regnum2_o   = regnum2_q;
    assign din0_o      = din0_q;
    assign err_range_o = err_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: vector table, contention sequence and write scoreboard for gpr_wb_arbiter
module tb_gpr_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, alu_valid, alu_ready, mem_valid, mem_ready, we0;
    logic [4:0]  alu_regnum, mem_regnum, regnum2, rd0, rd1;
    logic [31:0] alu_data, mem_data, din0, byp_data0, byp_data1;
    logic        byp_hit0, byp_hit1, err_range;

    gpr_wb_arbiter #(.NREG(16), .MAXWAIT(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_regnum_i(alu_regnum), .alu_data_i(alu_data),
        .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_regnum_i(mem_regnum), .mem_data_i(mem_data),
        .regnum2_o(regnum2), .din0_o(din0), .we0_o(we0),
        .rd_regnum0_i(rd0), .rd_regnum1_i(rd1),
        .byp_hit0_o(byp_hit0), .byp_data0_o(byp_data0),
        .byp_hit1_o(byp_hit1), .byp_data1_o(byp_data1),
        .err_range_o(err_range)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst_n; logic av; logic [4:0] ar; logic [31:0] ad;
        logic mv; logic [4:0] mr; logic [31:0] md; logic [4:0] rd0, rd1;
        logic ea, em, we; logic [4:0] r2; logic [31:0] d0;
        logic h0; logic [31:0] b0; logic h1; logic [31:0] b1; logic err;
    } vec_t;

    typedef struct packed { logic [4:0] r; logic [31:0] d; } wr_t;

    localparam logic H = 1'b1, L = 1'b0;
    localparam logic [31:0] D1 = 32'h0000_3333, E1 = 32'h4444_0001, E2 = 32'h4444_0002;
    localparam logic [31:0] E3 = 32'h4444_0003, VA = 32'hAAAA_0000, VB = 32'hBBBB_0000, V5 = 32'h1234_5678;

    vec_t tbl[23];
    wr_t  alu_q[$], mem_q[$];
    int   n_chk = 0, n_fail = 0, row = 0, ka = 0, km = 0;
    logic err_exp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, row, act, exp);
        end
    endtask

    // Every committed write must be the oldest outstanding entry of one source;
    // accepted in-range entries are queued, reset discards them.
    task automatic sb();
        if (we0) begin
            n_chk++;
            if (alu_q.size() > 0 && alu_q[0] == {regnum2, din0}) void'(alu_q.pop_front());
            else if (mem_q.size() > 0 && mem_q[0] == {regnum2, din0}) void'(mem_q.pop_front());
            else begin
                n_fail++;
                $display("FAIL write (step %0d): got r%0d=%h, expected a pending entry (alu %0d, mem %0d pending)",
                         row, regnum2, din0, alu_q.size(), mem_q.size());
            end
        end
        chk("err_range_sb", err_range, err_exp);
        err_exp = rst_n && ((alu_valid && alu_ready && alu_regnum >= 5'd16) ||
                            (mem_valid && mem_ready && mem_regnum >= 5'd16));
        if (!rst_n) begin
            alu_q.delete();
            mem_q.delete();
        end else begin
            if (alu_valid && alu_ready && alu_regnum != 5'd0 && alu_regnum < 5'd16) alu_q.push_back({alu_regnum, alu_data});
            if (mem_valid && mem_ready && mem_regnum != 5'd0 && mem_regnum < 5'd16) mem_q.push_back({mem_regnum, mem_data});
        end
    endtask

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        alu_regnum = 5'd0; mem_regnum = 5'd0; alu_data = 32'd0; mem_data = 32'd0; rd0 = 5'd0; rd1 = 5'd0;
        //            rst av ar     ad             mv mr      md             rd0    rd1     ea em we r2     d0      h0 b0     h1 b1     err
        for (int i = 0; i < 3; i++)
            tbl[i] = '{L, H, 5'd5,  32'h11,        H, 5'd6,  32'h22,        5'd5,  5'd6,  L, L, L, 5'd0, 32'd0, L, 32'd0, L, 32'd0, L};
        tbl[3]  = '{H, H, 5'd5,  V5,            L, 5'd0,  32'd0,         5'd5,  5'd0,  H, H, L, 5'd0, 32'd0, L, 32'd0, L, 32'd0, L};
        tbl[4]  = '{H, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd5,  5'd5,  H, H, L, 5'd0, 32'd0, H, V5,    H, V5,    L};
        tbl[5]  = '{H, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd5,  5'd3,  H, H, H, 5'd5, V5,    H, V5,    L, 32'd0, L};
        tbl[6]  = '{H, H, 5'd0,  32'hDEAD0001,  H, 5'd20, 32'hDEAD0002,  5'd5,  5'd20, H, H, L, 5'd5, V5,    L, 32'd0, L, 32'd0, L};
        tbl[7]  = '{H, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd0,  5'd20, H, H, L, 5'd5, V5,    L, 32'd0, L, 32'd0, H};
        tbl[8]  = '{H, H, 5'd31, 32'h1,         H, 5'd16, 32'h2,         5'd0,  5'd16, H, H, L, 5'd5, V5,    L, 32'd0, L, 32'd0, L};
        tbl[9]  = '{H, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd0,  5'd16, H, H, L, 5'd5, V5,    L, 32'd0, L, 32'd0, H};
        tbl[10] = '{H, H, 5'd9,  32'h99,        H, 5'd10, 32'hA0,        5'd9,  5'd10, H, H, L, 5'd5, V5,    L, 32'd0, L, 32'd0, L};
        tbl[11] = '{L, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd9,  5'd10, L, L, L, 5'd5, V5,    H, 32'h99, H, 32'hA0, L};
        tbl[12] = '{H, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd9,  5'd10, H, H, L, 5'd0, 32'd0, L, 32'd0, L, 32'd0, L};
        tbl[13] = tbl[12];
        tbl[14] = '{H, H, 5'd3,  D1,            H, 5'd4,  E1,            5'd7,  5'd4,  H, H, L, 5'd0, 32'd0, L, 32'd0, L, 32'd0, L};
        tbl[15] = '{H, L, 5'd0,  32'd0,         H, 5'd4,  E2,            5'd7,  5'd4,  L, H, L, 5'd0, 32'd0, L, 32'd0, H, E1,    L};
        tbl[16] = '{H, L, 5'd0,  32'd0,         H, 5'd4,  E3,            5'd7,  5'd4,  L, H, H, 5'd4, E1,    L, 32'd0, H, E2,    L};
        tbl[17] = '{H, L, 5'd0,  32'd0,         H, 5'd7,  VA,            5'd7,  5'd4,  L, H, H, 5'd4, E2,    L, 32'd0, H, E3,    L};
        tbl[18] = '{H, H, 5'd7,  VB,            L, 5'd0,  32'd0,         5'd7,  5'd4,  H, L, H, 5'd4, E3,    H, VA,    H, E3,    L};
        tbl[19] = '{H, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd7,  5'd4,  L, H, H, 5'd3, D1,    H, VB,    L, 32'd0, L};
        tbl[20] = '{H, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd7,  5'd4,  H, H, H, 5'd7, VA,    H, VB,    L, 32'd0, L};
        tbl[21] = '{H, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd7,  5'd4,  H, H, H, 5'd7, VB,    H, VB,    L, 32'd0, L};
        tbl[22] = '{H, L, 5'd0,  32'd0,         L, 5'd0,  32'd0,         5'd7,  5'd4,  H, H, L, 5'd7, VB,    L, 32'd0, L, 32'd0, L};

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            row = i;
            rst_n = tbl[i].rst_n;
            alu_valid = tbl[i].av; alu_regnum = tbl[i].ar; alu_data = tbl[i].ad;
            mem_valid = tbl[i].mv; mem_regnum = tbl[i].mr; mem_data = tbl[i].md;
            rd0 = tbl[i].rd0; rd1 = tbl[i].rd1;
            #1;
            chk("alu_ready", alu_ready, tbl[i].ea);
            chk("mem_ready", mem_ready, tbl[i].em);
            chk("we0", we0, tbl[i].we);
            chk("regnum2", regnum2, tbl[i].r2);
            chk("din0", din0, tbl[i].d0);
            chk("byp_hit0", byp_hit0, tbl[i].h0);
            chk("byp_data0", byp_data0, tbl[i].b0);
            chk("byp_hit1", byp_hit1, tbl[i].h1);
            chk("byp_data1", byp_data1, tbl[i].b1);
            chk("err_range", err_range, tbl[i].err);
            sb();
            @(negedge clk);
        end

        // Both sources stream continuously: MEM wins three times, then the guard hands ALU one slot.
        for (int c = 0; c < 17; c++) begin
            row = 100 + c;
            alu_valid = 1'b1; alu_regnum = 5'd3; alu_data = 32'hC000_0000 | 32'(ka);
            mem_valid = 1'b1; mem_regnum = 5'd4; mem_data = 32'hD000_0000 | 32'(km);
            rd0 = 5'd0; rd1 = 5'd0;
            #1;
            chk("stream_alu_ready", alu_ready, (c == 0) || ((c - 1) % 4 == 3));
            chk("stream_mem_ready", mem_ready, (c == 0) || ((c - 1) % 4 != 3));
            chk("stream_we0", we0, c >= 2);
            if (c >= 2) chk("stream_regnum2", regnum2, ((c - 2) % 4 == 3) ? 32'd3 : 32'd4);
            if (alu_valid && alu_ready) ka++;
            if (mem_valid && mem_ready) km++;
            sb();
            @(negedge clk);
        end

        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            row = 200 + c;
            #1;
            sb();
            @(negedge clk);
        end
        chk("alu_left_pending", alu_q.size(), 32'd0);
        chk("mem_left_pending", mem_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single write port of the general-purpose register file (16 x 32-bit, REGNUM2/DIN0/WE0) between two writeback sources: the ALU and the memory-load path.
- Each source has a one-entry holding buffer with valid/ready handshake; a fixed-priority arbiter with starvation guard drives a registered write port.
- Provides forwarding to both register-file read ports so decode sees writes that are pending but not yet committed.

Parameters:
- NREG, 16, number of implemented registers; REGNUM >= NREG is out of range
- MAXWAIT, 3, consecutive lost arbitrations after which ALU wins over MEM (1..15)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  synchronous active-low reset
- ALU_VALID  in  1  ALU writeback request
- ALU_READY  out  1  ALU buffer can accept
- ALU_REGNUM  in  5  ALU destination register
- ALU_DATA  in  32  ALU result
- MEM_VALID  in  1  load writeback request
- MEM_READY  out  1  MEM buffer can accept
- MEM_REGNUM  in  5  load destination register
- MEM_DATA  in  32  load data
- REGNUM2  out  5  register-file write address (registered)
- DIN0  out  32  register-file write data (registered)
- WE0  out  1  register-file write enable (registered)
- RD_REGNUM0, RD_REGNUM1  in  5 each  register-file read addresses (REGNUM0/REGNUM1)
- BYP_HIT0, BYP_HIT1  out  1 each  forwarded value valid for read port 0/1
- BYP_DATA0, BYP_DATA1  out  32 each  forwarded value
- ERR_RANGE  out  1  one-cycle pulse: out-of-range write dropped

Behaviour:
- Reset (RST_N=0 at an edge): both buffers empty, age bit cleared, wait counter 0. WE0=0, REGNUM2=0, DIN0=0, ERR_RANGE=0. ALU_READY=MEM_READY=0 while RST_N=0. Reset mid-operation discards pending entries; no write is issued afterwards.
- Handshake: a transfer occurs at an edge where VALID=1 and READY=1. READY is combinational: 1 when the buffer is empty, or when it is full and granted this cycle (skid, so a full-rate stream is possible).
- Filter at accept: REGNUM=0 means the transfer completes but is discarded (buffer not loaded). REGNUM>=NREG means it is discarded and ERR_RANGE pulses the next cycle. If both sources are out of range in the same cycle, ERR_RANGE gives a single pulse.
- Age: when a buffer loads while the other buffer is full and not being drained, the loading buffer is marked younger. If both load in the same edge, ALU is younger.
- Grant (combinational, at most one per cycle), in priority order:
  1. Both full with equal REGNUM: grant the older entry.
  2. Both full and wait counter >= MAXWAIT: grant ALU.
  3. Otherwise grant MEM if full, else ALU if full.
- Wait counter: increments when ALU is full and not granted, saturating at 15. Clears when ALU is granted or empty.
- Write port: at the edge after a grant, WE0<=1 and REGNUM2/DIN0 <= the granted entry, and that buffer empties (unless it is refilled via skid). With no grant, WE0<=0 and REGNUM2/DIN0 hold their values.
- Latency: accept at edge N, WE0 high in cycle N+1, register file written at edge N+2 (minimum; more if arbitration is lost).
- Forwarding, per port k, combinational:
  - HIT when RD_REGNUMk != 0 and it matches the younger full buffer, else the older full buffer, else REGNUM2 with WE0=1. BYP_DATAk comes from the first match in that order.
  - If there is no match: HIT=0 and DATA=0.
  - Entries filtered at accept never forward.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with both VALIDs high -> READYs 0, WE0=0, no accept. Release -> first accepts at the next edge.
- Single ALU write: ALU_REGNUM=5, ALU_DATA=0x12345678 accepted at edge N -> WE0=1, REGNUM2=5, DIN0=0x12345678 in cycle N+1; BYP_HIT0=1 for RD_REGNUM0=5 in cycles N..N+1.
- Contention and starvation: both VALID continuously with REGNUM 3 (ALU) and 4 (MEM), MAXWAIT=3 -> MEM granted 3 times, then ALU once; pattern repeats, no loss, READY toggles via skid.
- Same-register ordering: MEM r7=0xAAAA0000 accepted while ALU r7=0xBBBB0000 is accepted one edge later with MEM still blocked -> writes committed MEM then ALU; BYP_DATA for r7 = 0xBBBB0000 while both are pending.
- Filtering: ALU_REGNUM=0 -> accepted, no WE0, no bypass hit. MEM_REGNUM=20 -> accepted, ERR_RANGE pulses once, no WE0.
- Reset mid-operation: both buffers full, RST_N=0 for one edge -> WE0=0 afterwards, and the pending registers are never written.
